regfile_wb_arbiter: RTL

- Shares the single register-file write port (RegWrite/WriteAddr/WriteData) among NREQ writeback requesters: ALU, load unit, link/jal path.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives the register file through one registered output stage.
- Also suppresses writes to register 0, honours a pipeline freeze, and keeps a saturating count of committed writes for debug.

---
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port among NREQ writeback sources.
// A single registered stage presents the winning write one cycle after acceptance.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     freeze,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WriteAddr,
  output logic [DATA_W-1:0]        WriteData,
  output logic [2:0]               grant_id,
  output logic [CNT_W-1:0]         wr_count
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   gnt_idx;
  logic              gnt_found;
  logic              gnt_valid;
  logic              wr_en;
  int unsigned       cand;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              regwrite_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        gid_q;
  logic [CNT_W-1:0]  wr_count_q;

  // Search starts at ptr and wraps, so the last winner has lowest priority next cycle.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr_q) + k) % NREQ;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = PtrW'(cand);
      end
    end
  end

  // Reset gating keeps req_ready quiet for the whole asynchronous reset window.
  assign gnt_valid = gnt_found && !freeze && rst_n;

  always_comb begin
    req_ready = '0;
    if (gnt_valid) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign sel_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[gnt_idx*DATA_W +: DATA_W];
  assign ptr_d    = (gnt_idx == PtrW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Writes to x0 still win arbitration but never reach the register file.
  assign wr_en = gnt_valid && (sel_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      gid_q      <= '0;
      wr_count_q <= '0;
    end else begin
      regwrite_q <= wr_en;
      if (gnt_valid) begin
        ptr_q   <= ptr_d;
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
        gid_q   <= 3'(gnt_idx);
      end
      if (wr_en && (wr_count_q != '1)) begin
        wr_count_q <= wr_count_q + 1'b1;
      end
    end
  end

  assign RegWrite  = regwrite_q;
  assign WriteAddr = waddr_q;
  assign WriteData = wdata_q;
  assign grant_id  = gid_q;
  assign wr_count  = wr_count_q;

endmodule
